// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit path (and the future receiver).
//   mode_e     : I2S_MODE (MSB one bit clock after word_select edge) or
//                LJ_MODE (MSB on the word_select edge)
//   underrun_e : UR_ZERO (send zeros) or UR_REPEAT (resend last pair)
//   cnt_width  : counter width for a counter that must hold 0..n-1,
//                never less than one bit
package i2s_pkg;

  typedef enum logic {
    I2S_MODE = 1'b0,
    LJ_MODE  = 1'b1
  } mode_e;

  typedef enum logic {
    UR_ZERO   = 1'b0,
    UR_REPEAT = 1'b1
  } underrun_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: divides clk by SCLK_DIV into a 50% duty serial_clk and
// flags the clk edge on which serial_clk toggles.
//   clk        in  master clock
//   rst_n      in  synchronous active-low reset
//   serial_clk out bit clock, starts low after reset
//   fall_en    out high in the cycle whose closing edge drives serial_clk 1->0
//   rise_en    out high in the cycle whose closing edge drives serial_clk 0->1
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic serial_clk,
  output logic fall_en,
  output logic rise_en
);

  localparam int unsigned HALF = SCLK_DIV / 2;
  localparam int unsigned CW   = cnt_width(HALF);
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          term;

  always_comb begin
    term      = (div_cnt_q == TERM);
    div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
    sclk_d    = term ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign serial_clk = sclk_q;
  assign fall_en    = term & sclk_q;
  assign rise_en    = term & ~sclk_q;

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified serial audio transmitter.
// Accepts sample pairs on a valid/ready stream into a one-pair holding
// register and serialises one frame (left slot, right slot) per
// 2*SLOT_WIDTH bit clocks, all from input_clk.
//   input_clk     in  master clock
//   reset         in  synchronous active-low reset
//   s_valid       in  sample pair valid
//   s_ready       out holding register empty
//   s_left        in  left sample, two's complement
//   s_right       in  right sample, two's complement
//   mute          in  sampled at frame boundary, zeros that frame
//   dac_mclk      out input_clk pass-through
//   serial_clk    out bit clock (input_clk / SCLK_DIV)
//   word_select   out 0 = left slot, 1 = right slot
//   sound_bit_out out serial data, changes with serial_clk falling
//   frame_start   out one-cycle pulse per frame boundary
//   underrun      out one-cycle pulse when a boundary finds holding empty
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned SLOT_WIDTH    = 32,
  parameter int unsigned SCLK_DIV      = 4,
  parameter mode_e       MODE          = I2S_MODE,
  parameter underrun_e   UNDERRUN_MODE = UR_ZERO
) (
  input  logic                    input_clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    mute,
  output logic                    dac_mclk,
  output logic                    serial_clk,
  output logic                    word_select,
  output logic                    sound_bit_out,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned BW         = cnt_width(FRAME_BITS);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_WIDTH);

  logic fall_en;
  logic rise_en_unused;

  i2s_bclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_bclk_gen (
    .clk        (input_clk),
    .rst_n      (reset),
    .serial_clk (serial_clk),
    .fall_en    (fall_en),
    .rise_en    (rise_en_unused)
  );

  logic [BW-1:0]           b_q, b_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    dly_q, dly_d;
  logic                    sd_q, sd_d;
  logic                    ws_q, ws_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic                    s_ready_q, s_ready_d;
  logic                    boundary;
  logic                    lj_bit;
  logic [FRAME_BITS-1:0]   new_frame;

  // Samples sit left-aligned in their slot with zero padding after the LSB.
  function automatic logic [FRAME_BITS-1:0] pack_pair(input logic [SAMPLE_WIDTH-1:0] l,
                                                      input logic [SAMPLE_WIDTH-1:0] r);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: SAMPLE_WIDTH] = l;
    f[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r;
    return f;
  endfunction

  always_comb begin
    b_d           = b_q;
    shift_d       = shift_q;
    dly_d         = dly_q;
    sd_d          = sd_q;
    ws_d          = ws_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    new_frame     = '0;
    lj_bit        = 1'b0;
    boundary      = fall_en && (b_q == B_LAST);

    // s_ready_q is only high while holding is empty, so a capture here never
    // collides with a boundary consuming the holding register.
    if (s_valid && s_ready_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end

    if (fall_en) begin
      if (boundary) begin
        b_d           = '0;
        frame_start_d = 1'b1;
        if (mute) begin
          // Muted frame still drains a waiting pair so the stream keeps pace.
          if (hold_full_q) begin
            hold_full_d = 1'b0;
          end
        end else if (hold_full_q) begin
          new_frame   = pack_pair(hold_l_q, hold_r_q);
          hold_full_d = 1'b0;
          last_l_d    = hold_l_q;
          last_r_d    = hold_r_q;
        end else begin
          underrun_d = 1'b1;
          if (UNDERRUN_MODE == UR_REPEAT) begin
            new_frame = pack_pair(last_l_q, last_r_q);
          end
        end
        // Frame MSB goes out on this same fall; the register keeps the rest.
        lj_bit  = new_frame[FRAME_BITS-1];
        shift_d = {new_frame[FRAME_BITS-2:0], 1'b0};
      end else begin
        b_d     = b_q + 1'b1;
        lj_bit  = shift_q[FRAME_BITS-1];
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end

      ws_d = (b_d >= SLOT_B);
      if (MODE == LJ_MODE) begin
        sd_d = lj_bit;
      end else begin
        // I2S: data trails word_select by one bit clock.
        sd_d  = dly_q;
        dly_d = lj_bit;
      end
    end

    s_ready_d = ~hold_full_d;
  end

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      b_q           <= B_LAST;
      shift_q       <= '0;
      dly_q         <= 1'b0;
      sd_q          <= 1'b0;
      ws_q          <= 1'b1;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      last_l_q      <= '0;
      last_r_q      <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      s_ready_q     <= 1'b0;
    end else begin
      b_q           <= b_d;
      shift_q       <= shift_d;
      dly_q         <= dly_d;
      sd_q          <= sd_d;
      ws_q          <= ws_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      s_ready_q     <= s_ready_d;
    end
  end

  assign dac_mclk      = input_clk;
  assign s_ready       = s_ready_q;
  assign word_select   = ws_q;
  assign sound_bit_out = sd_q;
  assign frame_start   = frame_start_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: dut A uses the defaults (I2S, 16/32, /4, UR_ZERO),
// dut B is LJ 24/24, /2, UR_REPEAT. Directed vectors, hand-computed frames.
module tb_i2s_tx_stream;
  import i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_mute, a_ready, a_mclk, a_sclk, a_ws, a_sd, a_fs, a_ur;
  logic [15:0] a_l, a_r;
  logic        b_rst, b_valid, b_mute, b_ready, b_mclk, b_sclk, b_ws, b_sd, b_fs, b_ur;
  logic [23:0] b_l, b_r;

  i2s_tx_stream #(
    .SAMPLE_WIDTH (16), .SLOT_WIDTH (32), .SCLK_DIV (4),
    .MODE (I2S_MODE), .UNDERRUN_MODE (UR_ZERO)
  ) u_dut_a (
    .input_clk (clk), .reset (a_rst), .s_valid (a_valid), .s_ready (a_ready),
    .s_left (a_l), .s_right (a_r), .mute (a_mute), .dac_mclk (a_mclk),
    .serial_clk (a_sclk), .word_select (a_ws), .sound_bit_out (a_sd),
    .frame_start (a_fs), .underrun (a_ur)
  );

  i2s_tx_stream #(
    .SAMPLE_WIDTH (24), .SLOT_WIDTH (24), .SCLK_DIV (2),
    .MODE (LJ_MODE), .UNDERRUN_MODE (UR_REPEAT)
  ) u_dut_b (
    .input_clk (clk), .reset (b_rst), .s_valid (b_valid), .s_ready (b_ready),
    .s_left (b_l), .s_right (b_r), .mute (b_mute), .dac_mclk (b_mclk),
    .serial_clk (b_sclk), .word_select (b_ws), .sound_bit_out (b_sd),
    .frame_start (b_fs), .underrun (b_ur)
  );

  bit   sel;
  logic cur_fs, cur_ur, cur_sd, cur_ws, cur_rdy;
  assign cur_fs  = sel ? b_fs    : a_fs;
  assign cur_ur  = sel ? b_ur    : a_ur;
  assign cur_sd  = sel ? b_sd    : a_sd;
  assign cur_ws  = sel ? b_ws    : a_ws;
  assign cur_rdy = sel ? b_ready : a_ready;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic push(input bit s, input logic [23:0] l, input logic [23:0] r);
    int guard = 0;
    while (((s ? b_ready : a_ready) !== 1'b1) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("push_ready", 64'(s ? b_ready : a_ready), 64'd1);
    if (s) begin
      b_valid = 1'b1; b_l = l; b_r = r;
    end else begin
      a_valid = 1'b1; a_l = l[15:0]; a_r = r[15:0];
    end
    @(posedge clk); #1;
    if (s) b_valid = 1'b0; else a_valid = 1'b0;
    $display("push dut%0d L=%h R=%h at %0t", s, l, r, $time);
  endtask

  // Waits (bounded) for frame_start on the selected dut, then samples one bit
  // per bit clock. First bit of the frame ends up at bit nbits-1.
  task automatic capture(input int nbits, input int div,
                         output logic [63:0] sd_v, output logic [63:0] ws_v,
                         output logic ur, output logic rdy, output int waited);
    int guard = 0;
    sd_v = '0;
    ws_v = '0;
    while (cur_fs !== 1'b1 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    waited = guard;
    if (guard >= 1000) check_eq("frame_start_timeout", 64'(cur_fs), 64'd1);
    ur  = cur_ur;
    rdy = cur_rdy;
    for (int i = 0; i < nbits; i++) begin
      sd_v = {sd_v[62:0], cur_sd};
      ws_v = {ws_v[62:0], cur_ws};
      if (i < nbits - 1) begin
        repeat (div) @(posedge clk);
        #1;
      end
    end
    $display("frame dut%0d sd=%h ws=%h ur=%0b rdy=%0b waited=%0d", sel, sd_v, ws_v, ur, rdy, waited);
  endtask

  logic [63:0] sdv, wsv;
  logic        ur, rdy;
  int          waited;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers, fs_cnt, ur_cnt, rdy_ok;
    logic prev_rdy, pending;
    n_checks = 0; n_fail = 0; sel = 1'b0;
    a_rst = 0; b_rst = 0; a_valid = 0; b_valid = 0; a_mute = 0; b_mute = 0;
    a_l = '0; a_r = '0; b_l = '0; b_r = '0;

    // ---------------- dut A: defaults, I2S, UR_ZERO ----------------
    repeat (3) @(posedge clk);
    #1;
    check_eq("a_reset_state", 64'({a_sclk, a_ws, a_sd, a_ready, a_fs, a_ur}), 64'b010000);
    check_eq("a_mclk_passthru", 64'(a_mclk), 64'(clk));
    a_rst = 1'b1;
    @(posedge clk); #1;
    check_eq("a_ready_after_release", 64'(a_ready), 64'd1);
    push(0, 24'h008001, 24'h007FFE);
    check_eq("a_ready_low_after_xfer", 64'(a_ready), 64'd0);

    capture(64, 4, sdv, wsv, ur, rdy, waited);
    check_eq("a_i2s_data", sdv, 64'h40008000_3FFF0000);
    check_eq("a_i2s_ws", wsv, 64'h00000000_FFFFFFFF);
    check_eq("a_first_no_underrun", 64'(ur), 64'd0);
    check_eq("a_ready_at_fs", 64'(rdy), 64'd1);

    capture(64, 4, sdv, wsv, ur, rdy, waited);
    check_eq("a_frame_period", 64'(63 * 4 + waited), 64'd256);
    check_eq("a_urzero_underrun", 64'(ur), 64'd1);
    check_eq("a_urzero_data", sdv, 64'd0);

    // s_valid held high for three frames
    a_valid = 1'b1; a_l = 16'h1234; a_r = 16'hABCD;
    xfers = 0; fs_cnt = 0; ur_cnt = 0; rdy_ok = 0; pending = 1'b0;
    prev_rdy = a_ready;
    for (int c = 0; c < 768; c++) begin
      @(posedge clk); #1;
      if (prev_rdy && a_valid) xfers++;
      if (pending && !a_ready) rdy_ok++;
      pending = 1'b0;
      if (a_fs) begin
        fs_cnt++;
        if (a_ready) pending = 1'b1;
      end
      if (a_ur) ur_cnt++;
      prev_rdy = a_ready;
    end
    a_valid = 1'b0;
    check_eq("a_cont_xfers", 64'(xfers), 64'd4);
    check_eq("a_cont_frames", 64'(fs_cnt), 64'd3);
    check_eq("a_cont_underruns", 64'(ur_cnt), 64'd0);
    check_eq("a_cont_ready_pulse", 64'(rdy_ok), 64'd3);
    capture(64, 4, sdv, wsv, ur, rdy, waited);
    check_eq("a_cont_data", sdv, 64'h091A0000_55E68000);
    check_eq("a_cont_last_no_ur", 64'(ur), 64'd0);

    // mute across a boundary with a full holding register
    a_mute = 1'b1;
    push(0, 24'h00FFFF, 24'h00FFFF);
    capture(64, 4, sdv, wsv, ur, rdy, waited);
    a_mute = 1'b0;
    check_eq("a_mute_data", sdv, 64'd0);
    check_eq("a_mute_no_ur", 64'(ur), 64'd0);
    check_eq("a_mute_consumed_rdy", 64'(rdy), 64'd1);
    capture(64, 4, sdv, wsv, ur, rdy, waited);
    check_eq("a_after_mute_ur", 64'(ur), 64'd1);
    check_eq("a_after_mute_data", sdv, 64'd0);

    // reset in the right slot with a full holding register
    push(0, 24'h00FFFF, 24'h00FFFF);
    while (a_fs !== 1'b1) begin
      @(posedge clk); #1;
    end
    push(0, 24'h00AAAA, 24'h005555);
    repeat (160) @(posedge clk);
    #1;
    check_eq("a_in_right_slot", 64'(a_ws), 64'd1);
    a_rst = 1'b0;
    @(posedge clk); #1;
    check_eq("a_midreset_state", 64'({a_sclk, a_ws, a_sd, a_ready, a_fs, a_ur}), 64'b010000);
    a_rst = 1'b1;
    capture(64, 4, sdv, wsv, ur, rdy, waited);
    check_eq("a_first_fs_latency", 64'(waited), 64'd4);
    check_eq("a_hold_cleared_ur", 64'(ur), 64'd1);
    check_eq("a_hold_cleared_data", sdv, 64'd0);

    // ---------------- dut B: LJ, 24/24, /2, UR_REPEAT ----------------
    sel = 1'b1;
    check_eq("b_reset_state", 64'({b_sclk, b_ws, b_sd, b_ready, b_fs, b_ur}), 64'b010000);
    b_rst = 1'b1;
    // Transfer lands on the first boundary: no bypass, so that frame underruns.
    push(1, 24'hA5A5A5, 24'h5A5A5A);
    capture(48, 2, sdv, wsv, ur, rdy, waited);
    check_eq("b_nobypass_ur", 64'(ur), 64'd1);
    check_eq("b_nobypass_data", sdv, 64'd0);
    check_eq("b_lj_ws", wsv, 64'h0000_000000_FFFFFF);
    capture(48, 2, sdv, wsv, ur, rdy, waited);
    check_eq("b_frame_period", 64'(47 * 2 + waited), 64'd96);
    check_eq("b_lj_data", sdv, 64'h0000_A5A5A5_5A5A5A);
    check_eq("b_data_no_ur", 64'(ur), 64'd0);
    capture(48, 2, sdv, wsv, ur, rdy, waited);
    check_eq("b_repeat_ur", 64'(ur), 64'd1);
    check_eq("b_repeat_data", sdv, 64'h0000_A5A5A5_5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_stream.md
# i2s_tx_stream

Parametrised stereo I2S/left-justified serial audio transmitter: accepts stereo sample pairs over a valid/ready stream, buffers one pair, and serialises frames to the DAC from a single master clock with an internally divided bit clock. It replaces the fixed 16-bit, test-tone-only transmitter and sits between the audio processing pipeline and the external DAC pins.

## Interface
- SAMPLE_WIDTH, 16, bits per channel sample; 1..SLOT_WIDTH
- SLOT_WIDTH, 32, bit clocks per channel slot; 16..32; frame = 2*SLOT_WIDTH bit clocks
- SCLK_DIV, 4, input_clk cycles per serial_clk period; even, >= 2
- MODE, I2S_MODE, I2S_MODE (MSB one bit clock after word_select edge) or LJ_MODE (MSB on word_select edge)
- UNDERRUN_MODE, UR_ZERO, UR_ZERO (send zeros) or UR_REPEAT (resend last pair)

- input_clk  in  1  master clock, 12.288 MHz nominal
- reset  in  1  synchronous, active-low reset
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding register empty
- s_left  in  SAMPLE_WIDTH  left sample, two's complement
- s_right  in  SAMPLE_WIDTH  right sample, two's complement
- mute  in  1  sampled at frame boundary; forces zeros for that frame
- dac_mclk  out  1  equals input_clk (combinational pass-through)
- serial_clk  out  1  bit clock, input_clk / SCLK_DIV, 50% duty
- word_select  out  1  0 = left slot, 1 = right slot
- sound_bit_out  out  1  serial data, changes on serial_clk falling edge
- frame_start  out  1  one-cycle pulse at each frame boundary
- underrun  out  1  one-cycle pulse when a boundary finds the holding register empty

## Operation
- Clocking: all state on posedge input_clk. Divider counts 0..SCLK_DIV/2-1; on terminal count serial_clk toggles. Toggle 1->0 is the fall event; all of word_select, sound_bit_out, bit counter update on that same input_clk edge.
- Bit counter b: 0..2*SLOT_WIDTH-1, advances on each fall event, wraps to 0. Fall event with b wrapping to 0 is the frame boundary.
- word_select = (b >= SLOT_WIDTH) in both modes.
- Frame boundary: 2*SLOT_WIDTH-bit shift register loads {left, zero pad, right, zero pad}, MSB first, samples left-aligned in slot, SLOT_WIDTH-SAMPLE_WIDTH zero bits after each LSB. Source priority: mute -> all zeros (holding still consumed if full); holding full -> holding contents, holding cleared; holding empty -> zeros (UR_ZERO) or last loaded pair (UR_REPEAT), underrun pulses. frame_start pulses every boundary.
- LJ_MODE: sound_bit_out = shift register MSB at each fall event. I2S_MODE: one extra bit-clock delay flop; previous frame's right LSB is output at b = 0 of the next frame.
- Handshake: transfer when s_valid && s_ready at posedge input_clk; holding captures both samples; s_ready low from the next cycle until the holding register is consumed. No bypass: transfer coinciding with a boundary while empty -> underrun for this frame, data used at next boundary.
- mute has no effect between boundaries.

## Timing
- Reset (reset low at a posedge): serial_clk 0, word_select 1, sound_bit_out 0, s_ready 0, frame_start 0, underrun 0, b = 2*SLOT_WIDTH-1, divider 0, holding empty, last pair zero. Reset mid-frame aborts the frame immediately.
- s_ready = 1 on the first cycle after reset deasserts.
- First serial_clk rise SCLK_DIV/2 cycles after reset release; first frame boundary SCLK_DIV cycles after release.
- Frame period 2*SLOT_WIDTH*SCLK_DIV input_clk cycles (defaults: 256 cycles, 48 kHz).
- Latency pair accepted -> its MSB on pin: next boundary (LJ) or next boundary + SCLK_DIV cycles (I2S).
- s_ready rises the cycle after the consuming boundary.

## Structure
- Package i2s_pkg: mode_e {I2S_MODE, LJ_MODE}, underrun_e {UR_ZERO, UR_REPEAT}, helper function for counter widths ($clog2 of 2*SLOT_WIDTH and SCLK_DIV/2).
- Sub-module i2s_bclk_gen: divider producing serial_clk, fall_en, rise_en; reused by future receiver.

## Test plan
- Defaults, I2S: push L=16'h8001, R=16'h7FFE before first boundary -> after word_select falls, one bit clock gap, then 1000000000000001 followed by 16 zeros; right slot 0111111111111110 + 16 zeros; word_select high for 32 bit clocks.
- LJ_MODE, SAMPLE_WIDTH=24, SLOT_WIDTH=24, SCLK_DIV=2: L=24'hA5A5A5 -> MSB coincident with word_select fall, 48 bit clocks per frame, 96-cycle frame period.
- No data after one pair, UR_ZERO vs UR_REPEAT -> underrun pulses each subsequent boundary; output zeros vs repeated pair.
- s_valid held high continuously -> exactly one transfer per frame, s_ready high one cycle after each frame_start, no underrun after first frame.
- mute asserted across a boundary with a full holding register -> zero frame, holding consumed, no underrun.
- reset pulsed low mid right slot -> all outputs at reset values next cycle, holding cleared, first boundary SCLK_DIV cycles after release.
